// File: rtl/fifo_ctrl.sv
// fifo_ctrl
// Controller for a 1024 x 8 single-port external RAM used as a FIFO.
// One access (write or read) runs per two clock cycles, IDLE -> WR/RD -> IDLE.
// When both sides are eligible, a priority bit picks the winner.
// Every RAM control is decoded from the registered state alone.
//
// Ports
//   clk, rst_n                 system clock, async active-low reset
//   wr_req, wr_data, wr_ack    write handshake; wr_ack pulses in the WR cycle
//   rd_req, rd_ack             read handshake; rd_ack pulses in the RD cycle
//   rd_data, rd_valid          registered popped word; rd_valid pulses the cycle after RD
//   flush                      synchronous clear of pointers and count
//   full, empty, count         occupancy, 0..1024
//   ram_addr, ram_en, ram_cs,  RAM address and controls
//   ram_rws, ram_clk           ram_rws: 1 write, 0 read; ram_clk = ~clk
//   ram_wdata, ram_wdata_oe    write data and bus-driver enable
//   ram_rdata                  RAM bus as seen by the controller
module fifo_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic [10:0] count,
  output logic [9:0]  ram_addr,
  output logic        ram_en,
  output logic        ram_cs,
  output logic        ram_rws,
  output logic        ram_clk,
  output logic [7:0]  ram_wdata,
  output logic        ram_wdata_oe,
  input  logic [7:0]  ram_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [9:0] wptr;
  logic [9:0] rptr;
  logic       prio;       // 0: read wins a tie, 1: write wins a tie
  logic       wr_elig;
  logic       rd_elig;
  logic       grant_wr;
  logic       grant_rd;
  logic       in_wr;
  logic       in_rd;

  assign in_wr = (state == ST_WR);
  assign in_rd = (state == ST_RD);

  assign full  = (count == 11'd1024);
  assign empty = (count == 11'd0);

  assign wr_elig = wr_req & ~full;
  assign rd_elig = rd_req & ~empty;

  // Arbitration happens only in IDLE. Because of this, WR and RD always fall back to IDLE.
  // flush suppresses any grant in its cycle.
  always_comb begin
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    state_nxt = ST_IDLE;
    if (state == ST_IDLE && !flush) begin
      if (wr_elig && rd_elig) begin
        grant_wr = prio;
        grant_rd = ~prio;
      end else begin
        grant_wr = wr_elig;
        grant_rd = rd_elig;
      end
    end
    if (grant_wr)      state_nxt = ST_WR;
    else if (grant_rd) state_nxt = ST_RD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wptr     <= 10'd0;
      rptr     <= 10'd0;
      count    <= 11'd0;
      prio     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'd0;
    end else begin
      state <= state_nxt;

      // After a grant, priority passes to the other side.
      if (grant_wr)      prio <= 1'b0;
      else if (grant_rd) prio <= 1'b1;

      // A flush during an access lets the RAM cycle finish,
      // but the bookkeeping update for that access is dropped.
      if (flush) begin
        wptr  <= 10'd0;
        rptr  <= 10'd0;
        count <= 11'd0;
      end else if (in_wr) begin
        wptr  <= wptr + 10'd1;
        count <= count + 11'd1;
      end else if (in_rd) begin
        rptr  <= rptr + 10'd1;
        count <= count - 11'd1;
      end

      if (in_rd) rd_data <= ram_rdata;
      rd_valid <= in_rd & ~flush;
    end
  end

  // RAM interface, decoded from state only.
  assign wr_ack       = in_wr;
  assign rd_ack       = in_rd;
  assign ram_en       = in_wr | in_rd;
  assign ram_cs       = in_wr | in_rd;
  assign ram_rws      = in_wr;
  assign ram_wdata_oe = in_wr;
  assign ram_wdata    = in_wr ? wr_data : 8'd0;
  assign ram_addr     = in_wr ? wptr : (in_rd ? rptr : 10'd0);
  assign ram_clk      = ~clk;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl. A small RAM model is attached to the controller.
// Expected behaviour comes from a queue-based FIFO reference model.
module tb_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_req;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        flush;
  logic        full;
  logic        empty;
  logic [10:0] count;
  logic [9:0]  ram_addr;
  logic        ram_en;
  logic        ram_cs;
  logic        ram_rws;
  logic        ram_clk;
  logic [7:0]  ram_wdata;
  logic        ram_wdata_oe;
  logic [7:0]  ram_rdata;

  fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .flush(flush), .full(full), .empty(empty), .count(count),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_cs(ram_cs), .ram_rws(ram_rws),
    .ram_clk(ram_clk), .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: written on the ram_clk strobe, read asynchronously.
  logic [7:0] mem [0:1023];
  always @(posedge ram_clk) begin
    if (ram_cs && ram_en && ram_rws && ram_wdata_oe) mem[ram_addr] = ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  // Reference model
  logic [7:0] q[$];
  int m_wptr;
  int m_rptr;
  int n_cmp;
  int n_fail;

  typedef struct {
    logic [1:0]  op;        // 0 write, 1 read, 2 flush
    logic [7:0]  din;
    logic [10:0] exp_count;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t tbl [13];

  logic [7:0] rdv;
  logic [7:0] last_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_occ(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(q.size() == 1024));
  endtask

  // Called and returns at a negedge.
  task automatic op_write(input logic [7:0] d, input int budget);
    bit acked;
    bit expect_ack;
    acked = 1'b0;
    expect_ack = (q.size() < 1024);
    wr_data = d;
    wr_req  = 1'b1;
    for (int i = 0; i < budget && !acked; i++) begin
      @(negedge clk);
      if (wr_ack) acked = 1'b1;
    end
    wr_req = 1'b0;
    if (!expect_ack) begin
      chk("wr_full_noack", 32'(acked), 32'd0);
      @(negedge clk);
      chk_occ("wr_full");
      return;
    end
    if (!acked) begin
      chk("wr_ack_timeout", 32'd0, 32'd1);
      return;
    end
    chk("wr_ram_en",   32'(ram_en), 32'd1);
    chk("wr_ram_cs",   32'(ram_cs), 32'd1);
    chk("wr_ram_rws",  32'(ram_rws), 32'd1);
    chk("wr_ram_oe",   32'(ram_wdata_oe), 32'd1);
    chk("wr_ram_data", 32'(ram_wdata), 32'(d));
    chk("wr_ram_addr", 32'(ram_addr), 32'(m_wptr));
    q.push_back(d);
    m_wptr = (m_wptr + 1) % 1024;
    @(negedge clk);
    chk("wr_ack_pulse", 32'(wr_ack), 32'd0);
    chk_occ("wr");
  endtask

  task automatic op_read(output logic [7:0] d, input int budget);
    bit acked;
    logic [7:0] exp;
    acked = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < budget && !acked; i++) begin
      @(negedge clk);
      if (rd_ack) acked = 1'b1;
    end
    rd_req = 1'b0;
    if (q.size() == 0) begin
      chk("rd_empty_noack", 32'(acked), 32'd0);
      @(negedge clk);
      chk_occ("rd_empty");
      d = rd_data;
      return;
    end
    if (!acked) begin
      chk("rd_ack_timeout", 32'd0, 32'd1);
      d = rd_data;
      return;
    end
    chk("rd_ram_en",   32'(ram_en), 32'd1);
    chk("rd_ram_cs",   32'(ram_cs), 32'd1);
    chk("rd_ram_rws",  32'(ram_rws), 32'd0);
    chk("rd_ram_oe",   32'(ram_wdata_oe), 32'd0);
    chk("rd_ram_addr", 32'(ram_addr), 32'(m_rptr));
    exp = q.pop_front();
    m_rptr = (m_rptr + 1) % 1024;
    @(negedge clk);
    chk("rd_ack_pulse", 32'(rd_ack), 32'd0);
    chk("rd_valid",     32'(rd_valid), 32'd1);
    chk("rd_data",      32'(rd_data), 32'(exp));
    chk_occ("rd");
    d = rd_data;
  endtask

  task automatic op_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    q.delete();
    m_wptr = 0;
    m_rptr = 0;
    chk("flush_rd_valid", 32'(rd_valid), 32'd0);
    chk_occ("flush");
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; m_wptr = 0; m_rptr = 0;
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0; wr_data = 8'd0;

    tbl[0]  = '{2'd0, 8'hA5, 11'd1, 8'h00};
    tbl[1]  = '{2'd1, 8'h00, 11'd0, 8'hA5};
    tbl[2]  = '{2'd1, 8'h00, 11'd0, 8'hA5};
    tbl[3]  = '{2'd0, 8'h11, 11'd1, 8'hA5};
    tbl[4]  = '{2'd0, 8'h22, 11'd2, 8'hA5};
    tbl[5]  = '{2'd0, 8'h33, 11'd3, 8'hA5};
    tbl[6]  = '{2'd1, 8'h00, 11'd2, 8'h11};
    tbl[7]  = '{2'd0, 8'h44, 11'd3, 8'h11};
    tbl[8]  = '{2'd1, 8'h00, 11'd2, 8'h22};
    tbl[9]  = '{2'd2, 8'h00, 11'd0, 8'h22};
    tbl[10] = '{2'd1, 8'h00, 11'd0, 8'h22};
    tbl[11] = '{2'd0, 8'hFF, 11'd1, 8'h22};
    tbl[12] = '{2'd1, 8'h00, 11'd0, 8'hFF};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_count",  32'(count), 32'd0);
    chk("rst_empty",  32'(empty), 32'd1);
    chk("rst_full",   32'(full), 32'd0);
    chk("rst_acks",   32'({wr_ack, rd_ack, rd_valid}), 32'd0);
    chk("rst_ramctl", 32'({ram_en, ram_cs, ram_rws, ram_wdata_oe}), 32'd0);
    chk("rst_addr",   32'(ram_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven basic sequence (write A5 then read, empty read, holds, flush)
    for (int i = 0; i < 13; i++) begin
      case (tbl[i].op)
        2'd0:    op_write(tbl[i].din, 8);
        2'd1:    op_read(rdv, 8);
        default: op_flush();
      endcase
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_rdata", i), 32'(rd_data), 32'(tbl[i].exp_rdata));
    end

    // Fill to full, attempt an overfilling write, drain in order
    op_flush();
    for (int i = 0; i < 1024; i++) op_write(8'(i % 256), 8);
    chk("fill_full", 32'(full), 32'd1);
    op_write(8'h5A, 20);
    for (int i = 0; i < 1024; i++) begin
      op_read(rdv, 8);
      if (i % 128 == 0) chk("drain_seq", 32'(rdv), 32'(i % 256));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Pointer wrap past 1023
    op_flush();
    for (int i = 0; i < 1000; i++) op_write(8'($urandom), 8);
    for (int i = 0; i < 1000; i++) op_read(rdv, 8);
    for (int i = 0; i < 50; i++) op_write(8'($urandom), 8);
    for (int i = 0; i < 50; i++) op_read(rdv, 8);

    // Alternating grants with both requests held at count 5
    op_flush();
    for (int i = 0; i < 5; i++) op_write(8'(8'h60 + i), 8);
    wr_data = 8'h3C;
    wr_req = 1'b1;
    rd_req = 1'b1;
    last_pop = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("alt_rd_ack", 32'(rd_ack), 32'(i % 4 == 0));
      chk("alt_wr_ack", 32'(wr_ack), 32'(i % 4 == 2));
      chk("alt_count",  32'(count), 32'(q.size()));
      if (i % 4 == 1) begin
        chk("alt_rd_valid", 32'(rd_valid), 32'd1);
        chk("alt_rd_data",  32'(rd_data), 32'(last_pop));
      end
      if (i % 4 == 0) begin
        last_pop = q.pop_front();
        m_rptr = (m_rptr + 1) % 1024;
      end
      if (i % 4 == 2) begin
        q.push_back(8'h3C);
        m_wptr = (m_wptr + 1) % 1024;
      end
      if (i == 11) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
    end
    while (q.size() > 0) op_read(rdv, 8);

    // Flush during a WR cycle at count 7
    op_flush();
    for (int i = 0; i < 7; i++) op_write(8'(8'h70 + i), 8);
    wr_data = 8'h77;
    wr_req = 1'b1;
    @(negedge clk);
    chk("flwr_ack", 32'(wr_ack), 32'd1);
    flush = 1'b1;
    wr_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    q.delete(); m_wptr = 0; m_rptr = 0;
    chk("flwr_count", 32'(count), 32'd0);
    chk("flwr_empty", 32'(empty), 32'd1);
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flwr_no_rd", 32'({rd_ack, rd_valid}), 32'd0);
    end
    rd_req = 1'b0;
    @(negedge clk);

    // Randomized operations against the queue model
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0)       op_flush();
      else if (r < 11)  op_write(8'($urandom), 8);
      else              op_read(rdv, 8);
    end

    // Reset during an RD cycle
    op_flush();
    for (int i = 0; i < 3; i++) op_write(8'(8'h90 + i), 8);
    rd_req = 1'b1;
    @(negedge clk);
    chk("rstrd_ack", 32'(rd_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    rd_req = 1'b0;
    chk("rstrd_acks",   32'({wr_ack, rd_ack, rd_valid}), 32'd0);
    chk("rstrd_ramctl", 32'({ram_en, ram_cs, ram_rws, ram_wdata_oe}), 32'd0);
    chk("rstrd_addr",   32'(ram_addr), 32'd0);
    chk("rstrd_count",  32'(count), 32'd0);
    chk("rstrd_flags",  32'({empty, full}), 32'b10);
    chk("rstrd_rdata",  32'(rd_data), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstrd_no_valid", 32'(rd_valid), 32'd0);
    end
    rst_n = 1'b1;
    q.delete(); m_wptr = 0; m_rptr = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstrd_no_valid_after", 32'(rd_valid), 32'd0);
    end
    chk_occ("rstrd_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameters: none; depth fixed at 1024 words, width 8 bits.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 wr_req  in  1  write request; held high with wr_data stable until wr_ack.
REQ-005 wr_data  in  8  write word.
REQ-006 wr_ack  out  1  one-cycle pulse; word accepted and written.
REQ-007 rd_req  in  1  read request; held high until rd_ack.
REQ-008 rd_ack  out  1  one-cycle pulse; read access performed this cycle.
REQ-009 rd_data  out  8  registered read word.
REQ-010 rd_valid  out  1  one-cycle pulse; rd_data holds the popped word.
REQ-011 flush  in  1  synchronous clear of FIFO contents.
REQ-012 full  out  1  count == 1024.
REQ-013 empty  out  1  count == 0.
REQ-014 count  out  11  words stored, 0..1024.
REQ-015 ram_addr  out  10  RAM word address.
REQ-016 ram_en  out  1  RAM decoder enable.
REQ-017 ram_cs  out  1  RAM chip select.
REQ-018 ram_rws  out  1  RAM direction: 1 write, 0 read.
REQ-019 ram_clk  out  1  RAM write strobe clock, equal to ~clk.
REQ-020 ram_wdata  out  8  data driven onto RAM bus.
REQ-021 ram_wdata_oe  out  1  bus driver enable (tri-state at top level).
REQ-022 ram_rdata  in  8  RAM bus as seen by controller.

Function
REQ-023 FSM states IDLE, WR, RD; each access occupies exactly one cycle in WR or RD; WR and RD always return to IDLE (max one access per 2 cycles).
REQ-024 In IDLE: wr eligible = wr_req & !full; rd eligible = rd_req & !empty; only one eligible -> go to that state; none -> stay IDLE.
REQ-025 Both eligible: grant side named by 1-bit prio register (0 read, 1 write); prio toggles to the other side after every granted access.
REQ-026 WR cycle: ram_addr=wptr, ram_en=1, ram_cs=1, ram_rws=1, ram_wdata=wr_data, ram_wdata_oe=1, wr_ack=1; at cycle end wptr+1 mod 1024, count+1.
REQ-027 RD cycle: ram_addr=rptr, ram_en=1, ram_cs=1, ram_rws=0, ram_wdata_oe=0, rd_ack=1; at cycle end rd_data<=ram_rdata, rptr+1 mod 1024, count-1; rd_valid=1 in following cycle only.
REQ-028 IDLE: ram_en=0, ram_cs=0, ram_rws=0, ram_wdata_oe=0, ram_addr=0; all RAM controls decoded from registered state only (no combinational path from wr_req/rd_req).
REQ-029 full and empty derived from registered count; never simultaneously 1.
REQ-030 Write while full / read while empty: no grant, no ack, no pointer or count change; requester waits.
REQ-031 Pointers wrap 1023->0 without affecting count; count never exceeds 1024 or underflows.
REQ-032 flush high: next state IDLE, wptr=rptr=count=0, rd_valid next cycle=0; flush overrides any grant that cycle.
REQ-033 flush during WR/RD: RAM access and ack of current cycle still complete; its pointer/count update discarded; during RD rd_data still loads but rd_valid stays 0.
REQ-034 rd_data holds last popped value until next RD.

Reset
REQ-035 rst_n low (async): state IDLE, wptr=rptr=0, count=0, empty=1, full=0, prio=0, wr_ack=rd_ack=rd_valid=0, rd_data=0, all RAM controls 0.
REQ-036 rst_n low mid-access aborts immediately; that access is not counted and no ack/valid follows.

Verification
REQ-037 Reset, write 0xA5 then read -> wr_ack 1 cycle, count 1, rd_ack, rd_valid next cycle with rd_data=0xA5, empty=1.
REQ-038 Write 1024 words 0..255 repeating -> full=1 at count 1024; further wr_req gets no ack for 20 cycles; 1024 reads return same sequence, empty=1.
REQ-039 Fill 1000, drain 1000, write/read 50 more -> pointers wrap past 1023, data order preserved, count tracks exactly.
REQ-040 count=5, wr_req and rd_req held continuously -> grants alternate R,W,R,W starting with read; count stays 5/4.
REQ-041 flush asserted during a WR cycle at count 7 -> wr_ack pulses, next cycle count=0, empty=1, next rd_req not granted.
REQ-042 rst_n dropped in RD cycle -> outputs at reset values within same cycle, rd_valid never asserts.
